// File: rtl/jumpy_pkg.sv
// Shared constants and types for the jumpy game datapath.
// Covers the framebuffer geometry, the palette and the rectangle plotter state.
package jumpy_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;

  localparam logic [CW-1:0] COL_BLACK  = 3'b000;
  localparam logic [CW-1:0] COL_GREEN  = 3'b010;
  localparam logic [CW-1:0] COL_YELLOW = 3'b110;
  localparam logic [CW-1:0] COL_BLUE   = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } plot_state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row counter that walks a w x h rectangle in raster order.
// last flags the bottom-right pixel, i.e. the final pixel of the rectangle.
module raster_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  output logic [XW-1:0] i,
  output logic [YW-1:0] j,
  output logic          last
);

  logic col_end_s;

  assign col_end_s = (i == (w - {{(XW-1){1'b0}}, 1'b1}));
  assign last      = col_end_s && (j == (h - {{(YW-1){1'b0}}, 1'b1}));

  // Counter state: cleared on command accept, stepped once per draw cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      i <= {XW{1'b0}};
      j <= {YW{1'b0}};
    end else if (clear) begin
      i <= {XW{1'b0}};
      j <= {YW{1'b0}};
    end else if (en) begin
      if (col_end_s) begin
        i <= {XW{1'b0}};
        j <= j + {{(YW-1){1'b0}}, 1'b1};
      end else begin
        i <= i + {{(XW-1){1'b0}}, 1'b1};
        j <= j;
      end
    end else begin
      i <= i;
      j <= j;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle fill engine for the 160x120 vga_adapter: one clipped pixel write per clock.
// Output registers are loaded with the *next* pixel, so pixel k is visible in cycle k+1.
module rect_plotter #(
  parameter int SCREEN_W = jumpy_pkg::SCREEN_W,
  parameter int SCREEN_H = jumpy_pkg::SCREEN_H,
  parameter int XW       = jumpy_pkg::XW,
  parameter int YW       = jumpy_pkg::YW,
  parameter int CW       = jumpy_pkg::CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] rect_x,
  input  logic [YW-1:0] rect_y,
  input  logic [XW-1:0] rect_w,
  input  logic [YW-1:0] rect_h,
  input  logic [CW-1:0] rect_colour,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour_out,
  output logic          plot
);

  import jumpy_pkg::*;

  plot_state_t   state_r, state_nxt_s;
  logic [XW-1:0] x0_r, w_r;
  logic [YW-1:0] y0_r, h_r;
  logic [CW-1:0] col_r;

  logic [XW-1:0] i_s, ni_s, bx_s, ox_s;
  logic [YW-1:0] j_s, nj_s, by_s, oy_s;
  logic          last_s, col_end_s, drawing_s, empty_s;
  logic [XW:0]   xsum_s;
  logic [YW:0]   ysum_s;
  logic [CW-1:0] c_s;

  logic          plot_nxt_s, busy_nxt_s, done_nxt_s;
  logic [XW-1:0] x_nxt_s;
  logic [YW-1:0] y_nxt_s;
  logic [CW-1:0] colour_nxt_s;

  raster_counter #(.XW(XW), .YW(YW)) u_raster (
    .clk   (clk),
    .reset (reset),
    .clear (state_r == IDLE),
    .en    (state_r == DRAW),
    .w     (w_r),
    .h     (h_r),
    .i     (i_s),
    .j     (j_s),
    .last  (last_s)
  );

  assign empty_s   = (rect_w == {XW{1'b0}}) || (rect_h == {YW{1'b0}});
  assign col_end_s = (i_s == (w_r - {{(XW-1){1'b0}}, 1'b1}));
  assign ni_s      = col_end_s ? {XW{1'b0}} : (i_s + {{(XW-1){1'b0}}, 1'b1});
  assign nj_s      = col_end_s ? (j_s + {{(YW-1){1'b0}}, 1'b1}) : j_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = empty_s ? DONE : DRAW;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAW: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAW;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: pick the pixel that the output registers show next cycle
  always_comb begin
    bx_s      = {XW{1'b0}};
    by_s      = {YW{1'b0}};
    ox_s      = {XW{1'b0}};
    oy_s      = {YW{1'b0}};
    c_s       = {CW{1'b0}};
    drawing_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !empty_s) begin
          bx_s      = rect_x;
          by_s      = rect_y;
          c_s       = rect_colour;
          drawing_s = 1'b1;
        end else begin
          drawing_s = 1'b0;
        end
      end
      DRAW: begin
        if (!last_s) begin
          bx_s      = x0_r;
          by_s      = y0_r;
          ox_s      = ni_s;
          oy_s      = nj_s;
          c_s       = col_r;
          drawing_s = 1'b1;
        end else begin
          drawing_s = 1'b0;
        end
      end
      default: drawing_s = 1'b0;
    endcase

    xsum_s       = {1'b0, bx_s} + {1'b0, ox_s};
    ysum_s       = {1'b0, by_s} + {1'b0, oy_s};
    plot_nxt_s   = drawing_s && (xsum_s < (XW+1)'(SCREEN_W)) && (ysum_s < (YW+1)'(SCREEN_H));
    x_nxt_s      = drawing_s ? xsum_s[XW-1:0] : {XW{1'b0}};
    y_nxt_s      = drawing_s ? ysum_s[YW-1:0] : {YW{1'b0}};
    colour_nxt_s = drawing_s ? c_s : {CW{1'b0}};
    busy_nxt_s   = (state_nxt_s != IDLE);
    done_nxt_s   = (state_nxt_s == DONE);
  end

  // Command capture on the accepted start strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_r  <= {XW{1'b0}};
      y0_r  <= {YW{1'b0}};
      w_r   <= {XW{1'b0}};
      h_r   <= {YW{1'b0}};
      col_r <= {CW{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      x0_r  <= rect_x;
      y0_r  <= rect_y;
      w_r   <= rect_w;
      h_r   <= rect_h;
      col_r <= rect_colour;
    end else begin
      x0_r  <= x0_r;
      y0_r  <= y0_r;
      w_r   <= w_r;
      h_r   <= h_r;
      col_r <= col_r;
    end
  end

  // Registered adapter and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_out      <= {XW{1'b0}};
      y_out      <= {YW{1'b0}};
      colour_out <= {CW{1'b0}};
    end else begin
      plot       <= plot_nxt_s;
      busy       <= busy_nxt_s;
      done       <= done_nxt_s;
      x_out      <= x_nxt_s;
      y_out      <= y_nxt_s;
      colour_out <= colour_nxt_s;
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: handshake timing, clipping, start/reset
// interaction and a full-screen fill, all against hand-computed expectations.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rect_x;
  logic [6:0] rect_y;
  logic [7:0] rect_w;
  logic [6:0] rect_h;
  logic [2:0] rect_colour;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  int checks = 0;
  int errors = 0;

  rect_plotter dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .busy        (busy),
    .done        (done),
    .x_out       (x_out),
    .y_out       (y_out),
    .colour_out  (colour_out),
    .plot        (plot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctl = {busy, done, plot}
  task automatic chk_ctl(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, busy, done, plot}, {29'd0, exp});
  endtask

  task automatic chk_px(input string tag, input int x, input int y, input int c);
    chk(tag, {14'd0, x_out, y_out, colour_out}, {14'd0, x[7:0], y[6:0], c[2:0]});
  endtask

  task automatic cmd(input int x, input int y, input int w, input int h, input int c);
    start       = 1'b1;
    rect_x      = x[7:0];
    rect_y      = y[6:0];
    rect_w      = w[7:0];
    rect_h      = h[6:0];
    rect_colour = c[2:0];
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    rect_x = 8'd0; rect_y = 7'd0; rect_w = 8'd0; rect_h = 7'd0; rect_colour = 3'd0;
    tick(); tick();
    chk_ctl("reset_ctl", 3'b000);
    chk_px("reset_px", 0, 0, 0);
    reset = 1'b0;
    tick(); tick();

    // 2x2 at (10,20), colour 4
    cmd(10, 20, 2, 2, 4);
    tick(); start = 1'b0;
    chk_ctl("r22_c1", 3'b101); chk_px("r22_p0", 10, 20, 4);
    tick(); chk_ctl("r22_c2", 3'b101); chk_px("r22_p1", 11, 20, 4);
    tick(); chk_ctl("r22_c3", 3'b101); chk_px("r22_p2", 10, 21, 4);
    tick(); chk_ctl("r22_c4", 3'b101); chk_px("r22_p3", 11, 21, 4);
    tick(); chk_ctl("r22_done", 3'b110);
    tick(); chk_ctl("r22_idle", 3'b000);
    tick();

    // empty rectangle: w = 0
    cmd(3, 3, 0, 5, 2);
    tick(); start = 1'b0;
    chk_ctl("empty_done", 3'b110);
    tick(); chk_ctl("empty_idle", 3'b000);
    tick();

    // clipped 4x2 at (158,119)
    cmd(158, 119, 4, 2, 2);
    tick(); start = 1'b0;
    chk_ctl("clip_c1", 3'b101); chk_px("clip_p0", 158, 119, 2);
    tick(); chk_ctl("clip_c2", 3'b101); chk_px("clip_p1", 159, 119, 2);
    for (int k = 3; k <= 8; k++) begin
      tick(); chk_ctl("clip_off", 3'b100);
    end
    tick(); chk_ctl("clip_done", 3'b110);
    tick(); chk_ctl("clip_idle", 3'b000);
    tick();

    // start during DRAW is ignored
    cmd(5, 5, 3, 1, 1);
    tick(); start = 1'b0;
    chk_ctl("ign_c1", 3'b101); chk_px("ign_p0", 5, 5, 1);
    tick(); chk_ctl("ign_c2", 3'b101); chk_px("ign_p1", 6, 5, 1);
    cmd(0, 0, 1, 1, 7);
    tick(); start = 1'b0;
    chk_ctl("ign_c3", 3'b101); chk_px("ign_p2", 7, 5, 1);
    tick(); chk_ctl("ign_done", 3'b110);
    tick(); chk_ctl("ign_idle5", 3'b000);
    tick(); chk_ctl("ign_idle6", 3'b000);
    tick();

    // reset in the middle of a 4x4 draw
    cmd(30, 40, 4, 4, 5);
    tick(); start = 1'b0;
    chk_ctl("rst_c1", 3'b101);
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk_ctl("rst_c4_ctl", 3'b000); chk_px("rst_c4_px", 0, 0, 0);
    tick(); chk_ctl("rst_c5_ctl", 3'b000);
    cmd(1, 2, 1, 2, 6);
    tick(); start = 1'b0;
    chk_ctl("rst_new_c1", 3'b101); chk_px("rst_new_p0", 1, 2, 6);
    tick(); chk_ctl("rst_new_c2", 3'b101); chk_px("rst_new_p1", 1, 3, 6);
    tick(); chk_ctl("rst_new_done", 3'b110);
    tick(); chk_ctl("rst_new_idle", 3'b000);
    tick();

    // full-screen clear
    cmd(0, 0, 160, 120, 0);
    tick(); start = 1'b0;
    for (int j = 0; j < 120; j++) begin
      for (int i = 0; i < 160; i++) begin
        chk("fs_px", {15'd0, busy, done, plot, x_out, y_out},
            {15'd0, 1'b1, 1'b0, 1'b1, i[7:0], j[6:0]});
        tick();
      end
    end
    chk_ctl("fs_done", 3'b110);
    tick(); chk_ctl("fs_idle", 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
